// File: rtl/ucsbece154a_datapath_pkg.sv
// ucsbece154a_datapath_pkg
// Encodings shared by the multicycle controller and datapath: ALU operation
// codes, immediate formats, operand/result mux selects and the LUI opcode.
// Also provides the immediate-extend helper used by the datapath.
package ucsbece154a_datapath_pkg;

    localparam int DP_XLEN = 32;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Unknown formats extend to zero so a stray ImmSrc never produces X.
    function automatic logic [31:0] imm_extend(input logic [31:0] ir, input logic [2:0] sel);
        logic [31:0] imm;
        imm = '0;
        case (sel)
            IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            IMM_U:   imm = {ir[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ucsbece154a_datapath_if.sv
// ucsbece154a_datapath_if
// Bundle between the controller/memory side and the datapath.
//   master : controller + memory (drives control strobes and ReadData_i)
//   slave  : datapath (drives Adr_o, WriteData_o, decode fields, zero_o,
//            misalign_o)
interface ucsbece154a_datapath_if;
    import ucsbece154a_datapath_pkg::*;

    logic               PCWrite_i;
    logic               AdrSrc_i;
    logic               IRWrite_i;
    logic [1:0]         ResultSrc_i;
    logic [2:0]         ALUControl_i;
    logic [1:0]         ALUSrcA_i;
    logic [1:0]         ALUSrcB_i;
    logic [2:0]         ImmSrc_i;
    logic               RegWrite_i;
    logic [DP_XLEN-1:0] ReadData_i;
    logic [DP_XLEN-1:0] Adr_o;
    logic [DP_XLEN-1:0] WriteData_o;
    logic [6:0]         op_o;
    logic [2:0]         funct3_o;
    logic               funct7_o;
    logic               zero_o;
    logic               misalign_o;

    modport master (
        output PCWrite_i, AdrSrc_i, IRWrite_i, ResultSrc_i, ALUControl_i,
               ALUSrcA_i, ALUSrcB_i, ImmSrc_i, RegWrite_i, ReadData_i,
        input  Adr_o, WriteData_o, op_o, funct3_o, funct7_o, zero_o, misalign_o
    );

    modport slave (
        input  PCWrite_i, AdrSrc_i, IRWrite_i, ResultSrc_i, ALUControl_i,
               ALUSrcA_i, ALUSrcB_i, ImmSrc_i, RegWrite_i, ReadData_i,
        output Adr_o, WriteData_o, op_o, funct3_o, funct7_o, zero_o, misalign_o
    );

endinterface

// File: rtl/ucsbece154a_rf.sv
// ucsbece154a_rf
// 32x32 register file: two combinational read ports, one synchronous write
// port, synchronous active-high reset clears every entry. x0 reads as zero
// and is never written. A read of the entry being written in the same cycle
// returns the old contents (no bypass).
//   clk, reset      : clock / synchronous reset
//   a1, a2 -> rd1, rd2 : read ports
//   a3, we3, wd3    : write port
module ucsbece154a_rf (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic        we3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we3 && (a3 != 5'd0)) begin
            regs[a3] <= wd3;
        end
    end

    assign rd1 = (a1 == 5'd0) ? '0 : regs[a1];
    assign rd2 = (a2 == 5'd0) ? '0 : regs[a2];

endmodule

// File: rtl/ucsbece154a_datapath.sv
// ucsbece154a_datapath
// Multicycle RV32I datapath driven by the main controller FSM. Holds PC,
// OldPC, IR, Data, A, B, ALUOut, the register file, the extend unit and the
// ALU, and returns op/funct3/funct7/zero to the controller.
//   clk, reset : clock / synchronous active-high reset
//   dp         : control strobes, memory bus and decode/status outputs
// Optional: `define DATAPATH_MISALIGN_CHECK_EN enables the sticky misaligned
// access flag misalign_o; otherwise it is tied low.
module ucsbece154a_datapath
    import ucsbece154a_datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    ucsbece154a_datapath_if.slave  dp
);

    logic [XLEN-1:0] pc, old_pc, ir, data, a, b, alu_out;
    logic [XLEN-1:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
    logic            is_lui;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            data    <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (dp.PCWrite_i) pc <= result;
            if (dp.IRWrite_i) begin
                ir     <= dp.ReadData_i;
                old_pc <= pc;
            end
            data    <= dp.ReadData_i;
            a       <= rd1;
            b       <= rd2;
            alu_out <= alu_result;
        end
    end

    ucsbece154a_rf u_rf (
        .clk   (clk),
        .reset (reset),
        .a1    (ir[19:15]),
        .a2    (ir[24:20]),
        .a3    (ir[11:7]),
        .we3   (dp.RegWrite_i),
        .wd3   (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    assign imm_ext = imm_extend(ir, dp.ImmSrc_i);
    assign is_lui  = (ir[6:0] == OP_LUI);

    // LUI bypasses the controller's operand/op choice: the result is the
    // U-immediate itself, so SrcA is zeroed and the ALU passes SrcB through.
    always_comb begin
        src_a = '0;
        case (dp.ALUSrcA_i)
            SRCA_PC:    src_a = pc;
            SRCA_OLDPC: src_a = old_pc;
            SRCA_REG:   src_a = a;
            default:    src_a = '0;
        endcase
        if (is_lui) src_a = '0;

        src_b = '0;
        case (dp.ALUSrcB_i)
            SRCB_REG:  src_b = b;
            SRCB_IMM:  src_b = imm_ext;
            SRCB_FOUR: src_b = 32'd4;
            default:   src_b = '0;
        endcase

        alu_result = src_a + src_b;
        case (dp.ALUControl_i)
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = src_a + src_b;
        endcase
        if (is_lui) alu_result = src_b;

        result = '0;
        case (dp.ResultSrc_i)
            RES_ALUOUT:    result = alu_out;
            RES_DATA:      result = data;
            RES_ALURESULT: result = alu_result;
            default:       result = '0;
        endcase
    end

    assign dp.Adr_o       = dp.AdrSrc_i ? result : pc;
    assign dp.WriteData_o = b;
    assign dp.op_o        = ir[6:0];
    assign dp.funct3_o    = ir[14:12];
    assign dp.funct7_o    = ir[30];
    assign dp.zero_o      = (alu_result == '0);

`ifdef DATAPATH_MISALIGN_CHECK_EN
    logic misalign_q;

    // Flags any data-side access or PC load that is not word aligned; stays
    // set until reset so software can poll it after the fact.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if ((dp.AdrSrc_i && (dp.Adr_o[1:0] != 2'b00)) ||
                     (dp.PCWrite_i && (result[1:0] != 2'b00))) begin
            misalign_q <= 1'b1;
        end
    end

    assign dp.misalign_o = misalign_q;
`else
    assign dp.misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ucsbece154a_datapath.sv
// tb_ucsbece154a_datapath
// Directed RV32I instruction sequences plus randomized control streams,
// checked against a behavioural model of the datapath registers kept here.
module tb_ucsbece154a_datapath;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ucsbece154a_datapath_if bus();

    ucsbece154a_datapath #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .dp    (bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // Model architectural state
    logic [31:0] m_pc, m_old, m_ir, m_data, m_a, m_b, m_aluout;
    logic [31:0] m_rf [32];
    logic        m_mis;

    // Model expectations for the current cycle
    logic [31:0] e_adr, e_wd, e_alu, e_result;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7, e_zero, e_mis;

    // Immediates built by placing the field at the top of a word and
    // arithmetic-shifting it back down.
    function automatic logic [31:0] modelImm(input logic [31:0] ir, input logic [2:0] sel);
        logic [31:0] t;
        case (sel)
            3'b000: begin t = {ir[31:20], 20'b0}; return $signed(t) >>> 20; end
            3'b001: begin t = {ir[31:25], ir[11:7], 20'b0}; return $signed(t) >>> 20; end
            3'b010: begin t = {ir[31], ir[7], ir[30:25], ir[11:8], 20'b0}; return ($signed(t) >>> 20) * 2; end
            3'b011: begin t = {ir[31], ir[19:12], ir[20], ir[30:21], 12'b0}; return ($signed(t) >>> 12) * 2; end
            3'b100: return ir & 32'hFFFF_F000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] modelAlu(input logic [31:0] x, input logic [31:0] y, input logic [2:0] c);
        int sx, sy;
        sx = x; sy = y;
        if (c == 3'b001) return x - y;
        if (c == 3'b010) return x & y;
        if (c == 3'b011) return x | y;
        if (c == 3'b101) return (sx < sy) ? 32'd1 : 32'd0;
        return x + y;
    endfunction

    task automatic applyStimulus(input logic rst, input logic pcw, input logic adrsrc, input logic irw,
                                 input logic [1:0] rsrc, input logic [2:0] aluc, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [2:0] imms, input logic regw,
                                 input logic [31:0] rdata);
        logic [31:0] va, vb;
        reset            = rst;
        bus.PCWrite_i    = pcw;
        bus.AdrSrc_i     = adrsrc;
        bus.IRWrite_i    = irw;
        bus.ResultSrc_i  = rsrc;
        bus.ALUControl_i = aluc;
        bus.ALUSrcA_i    = sa;
        bus.ALUSrcB_i    = sb;
        bus.ImmSrc_i     = imms;
        bus.RegWrite_i   = regw;
        bus.ReadData_i   = rdata;
        va = (sa == 2'd0) ? m_pc : (sa == 2'd1) ? m_old : (sa == 2'd2) ? m_a : 32'd0;
        vb = (sb == 2'd0) ? m_b : (sb == 2'd1) ? modelImm(m_ir, imms) : (sb == 2'd2) ? 32'd4 : 32'd0;
        if (m_ir[6:0] == 7'h37) e_alu = vb;
        else e_alu = modelAlu(va, vb, aluc);
        e_result = (rsrc == 2'd0) ? m_aluout : (rsrc == 2'd1) ? m_data : (rsrc == 2'd2) ? e_alu : 32'd0;
        e_adr  = adrsrc ? e_result : m_pc;
        e_wd   = m_b;
        e_op   = m_ir[6:0];
        e_f3   = m_ir[14:12];
        e_f7   = m_ir[30];
        e_zero = (e_alu == 32'd0);
        e_mis  = m_mis;
        #1;
    endtask

    // Advance the model by one clock using the inputs currently driven,
    // then move the DUT through the same edge and park on the negedge.
    task automatic clockEdge();
        logic [31:0] na, nb;
        if (reset) begin
            m_pc = RESET_PC; m_old = 0; m_ir = 0; m_data = 0;
            m_a = 0; m_b = 0; m_aluout = 0; m_mis = 1'b0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
`ifdef DATAPATH_MISALIGN_CHECK_EN
            if ((bus.AdrSrc_i && e_adr[1:0] != 2'b00) || (bus.PCWrite_i && e_result[1:0] != 2'b00))
                m_mis = 1'b1;
`endif
            na = m_rf[m_ir[19:15]];
            nb = m_rf[m_ir[24:20]];
            if (bus.RegWrite_i && m_ir[11:7] != 5'd0) m_rf[m_ir[11:7]] = e_result;
            if (bus.IRWrite_i) begin
                m_old = m_pc;
                m_ir  = bus.ReadData_i;
            end
            if (bus.PCWrite_i) m_pc = e_result;
            m_data = bus.ReadData_i;
            m_aluout = e_alu;
            m_a = na;
            m_b = nb;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        clockEdge();
    endtask

    task automatic fetch(input logic [31:0] instr);
        applyStimulus(0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, instr);
        clockEdge();
    endtask

    // Fetch, decode, execute (SrcA/SrcB/op given), write ALUOut back to rd.
    task automatic execWb(input logic [31:0] instr, input logic [2:0] imms, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [2:0] aluc);
        fetch(instr);
        stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b10, aluc, sa, sb, imms, 0, 32'd0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 1, 32'd0);
        clockEdge();
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'h1234_5678);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== RESET_PC) begin failures++; $display("[TB] FAIL reset_adr: got %h expected %h", bus.Adr_o, RESET_PC); end
        checks++; if (bus.op_o !== 7'd0) begin failures++; $display("[TB] FAIL reset_op: got %h expected 00", bus.op_o); end
        checks++; if (bus.funct3_o !== 3'd0 || bus.funct7_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_funct: got %h/%b expected 0/0", bus.funct3_o, bus.funct7_o); end
        checks++; if (bus.WriteData_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_wd: got %h expected 0", bus.WriteData_o); end
        checks++; if (bus.zero_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_zero: got %b expected 1", bus.zero_o); end
        checks++; if (bus.misalign_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_misalign: got %b expected 0", bus.misalign_o); end
        clockEdge();
    endtask

    task automatic test_fetch();
        applyStimulus(0, 1, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 3'b000, 0, 32'h0050_0093);
        checks++; if (bus.Adr_o !== 32'd0) begin failures++; $display("[TB] FAIL fetch_adr: got %h expected 0", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b000, 2'b01, 2'b11, 3'b000, 0, 32'd0);
        checks++; if (bus.op_o !== 7'h13 || bus.funct3_o !== 3'd0 || bus.funct7_o !== 1'b0) begin failures++; $display("[TB] FAIL fetch_decode: got %h/%h/%b expected 13/0/0", bus.op_o, bus.funct3_o, bus.funct7_o); end
        checks++; if (bus.Adr_o !== 32'd0) begin failures++; $display("[TB] FAIL fetch_oldpc: got %h expected 0", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd4) begin failures++; $display("[TB] FAIL fetch_pc4: got %h expected 4", bus.Adr_o); end
        clockEdge();
    endtask

    task automatic test_addi();
        logic [31:0] instr;
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd5) begin failures++; $display("[TB] FAIL addi_alu: got %h expected 5", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 1, 32'd0);
        checks++; if (bus.Adr_o !== 32'd5) begin failures++; $display("[TB] FAIL addi_aluout: got %h expected 5", bus.Adr_o); end
        clockEdge();
        fetch(32'h0010_2423);
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b001, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd8) begin failures++; $display("[TB] FAIL sw_adr: got %h expected 8", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b001, 0, 32'd0);
        checks++; if (bus.WriteData_o !== 32'd5) begin failures++; $display("[TB] FAIL sw_wd_x1: got %h expected 5", bus.WriteData_o); end
        clockEdge();
        execWb(32'h0070_0013, 3'b000, 2'b10, 2'b01, 3'b000);
        instr = {7'd0, 5'd0, 5'd0, 3'b010, 5'd8, 7'b0100011};
        fetch(instr);
        stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.WriteData_o !== 32'd0) begin failures++; $display("[TB] FAIL x0_write: got %h expected 0", bus.WriteData_o); end
        clockEdge();
    endtask

    task automatic test_alu();
        logic [31:0] instr;
        execWb(32'h0070_0113, 3'b000, 2'b10, 2'b01, 3'b000);
        instr = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        fetch(instr); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b001, 2'b10, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL sub: got %h expected fffffffe", bus.Adr_o); end
        checks++; if (bus.zero_o !== 1'b0) begin failures++; $display("[TB] FAIL sub_zero: got %b expected 0", bus.zero_o); end
        clockEdge();
        instr = {7'd0, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011};
        fetch(instr); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b101, 2'b10, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd1) begin failures++; $display("[TB] FAIL slt_5_7: got %h expected 1", bus.Adr_o); end
        clockEdge();
        instr = {1'b0, 6'd0, 5'd1, 5'd1, 3'b000, 4'd0, 1'b0, 7'b1100011};
        fetch(instr); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b001, 2'b10, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.zero_o !== 1'b1) begin failures++; $display("[TB] FAIL beq_zero: got %b expected 1", bus.zero_o); end
        clockEdge();
        execWb(32'h8000_00B7, 3'b100, 2'b10, 2'b01, 3'b011);
        execWb(32'h0010_0113, 3'b000, 2'b10, 2'b01, 3'b000);
        instr = {7'd0, 5'd2, 5'd1, 3'b010, 5'd3, 7'b0110011};
        fetch(instr); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b101, 2'b10, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd1) begin failures++; $display("[TB] FAIL slt_signed_neg: got %h expected 1", bus.Adr_o); end
        clockEdge();
        instr = {7'd0, 5'd1, 5'd2, 3'b010, 5'd3, 7'b0110011};
        fetch(instr); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b101, 2'b10, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd0) begin failures++; $display("[TB] FAIL slt_signed_pos: got %h expected 0", bus.Adr_o); end
        clockEdge();
    endtask

    task automatic test_lui();
        fetch(32'h1234_51B7); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b011, 2'b10, 2'b01, 3'b100, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'h1234_5000) begin failures++; $display("[TB] FAIL lui_alu: got %h expected 12345000", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b001, 2'b00, 2'b01, 3'b100, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'h1234_5000) begin failures++; $display("[TB] FAIL lui_forced: got %h expected 12345000", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 1, 32'd0);
        clockEdge();
        fetch(32'h0030_2423); stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.WriteData_o !== 32'h1234_5000) begin failures++; $display("[TB] FAIL lui_rf_x3: got %h expected 12345000", bus.WriteData_o); end
        clockEdge();
    endtask

    task automatic test_load_store();
        fetch(32'h0080_2203); stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b000, 0, 32'd0);
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'hDEAD_BEEF);
        checks++; if (bus.Adr_o !== 32'd8) begin failures++; $display("[TB] FAIL lw_adr: got %h expected 8", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, 1, 32'd0);
        checks++; if (bus.Adr_o !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL lw_data: got %h expected deadbeef", bus.Adr_o); end
        clockEdge();
        fetch(32'h0040_2423); stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.WriteData_o !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL lw_rf_x4: got %h expected deadbeef", bus.WriteData_o); end
        clockEdge();
    endtask

    task automatic test_reset_midinstr();
        fetch(32'h0080_2203); stepIdle();
        applyStimulus(0, 1, 0, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b000, 0, 32'd0);
        clockEdge();
        applyStimulus(1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'hCAFE_F00D);
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b01, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_data: got %h expected 0", bus.Adr_o); end
        checks++; if (bus.op_o !== 7'd0 || bus.WriteData_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_ir_b: got %h/%h expected 0/0", bus.op_o, bus.WriteData_o); end
        clockEdge();
        applyStimulus(0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_aluout: got %h expected 0", bus.Adr_o); end
        clockEdge();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== RESET_PC) begin failures++; $display("[TB] FAIL rst_pc: got %h expected %h", bus.Adr_o, RESET_PC); end
        clockEdge();
        fetch(32'h0040_2423); stepIdle();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.WriteData_o !== 32'd0) begin failures++; $display("[TB] FAIL rst_rf: got %h expected 0", bus.WriteData_o); end
        clockEdge();
    endtask

    task automatic test_misalign();
        logic exp_set;
`ifdef DATAPATH_MISALIGN_CHECK_EN
        exp_set = 1'b1;
`else
        exp_set = 1'b0;
`endif
        fetch(32'h0060_2283); stepIdle();
        applyStimulus(0, 0, 1, 0, 2'b10, 3'b000, 2'b10, 2'b01, 3'b000, 0, 32'd0);
        checks++; if (bus.Adr_o !== 32'd6) begin failures++; $display("[TB] FAIL mis_adr: got %h expected 6", bus.Adr_o); end
        checks++; if (bus.misalign_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_pre: got %b expected 0", bus.misalign_o); end
        clockEdge();
        for (int i = 0; i < 3; i++) begin
            stepIdle();
            checks++; if (bus.misalign_o !== exp_set) begin failures++; $display("[TB] FAIL mis_sticky%0d: got %b expected %b", i, bus.misalign_o, exp_set); end
        end
        applyStimulus(1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        clockEdge();
        applyStimulus(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 3'b000, 0, 32'd0);
        checks++; if (bus.misalign_o !== 1'b0) begin failures++; $display("[TB] FAIL mis_clear: got %b expected 0", bus.misalign_o); end
        clockEdge();
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [6:0]  ops [6];
        ops = '{7'h37, 7'h13, 7'h03, 7'h23, 7'h33, 7'h63};
        for (int n = 0; n < 400; n++) begin
            rd = $urandom;
            if ($urandom_range(0, 3) != 0) rd[6:0] = ops[$urandom_range(0, 5)];
            applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                          2'($urandom), 3'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
                          1'($urandom), rd);
            checks++; if (bus.Adr_o !== e_adr) begin failures++; $display("[TB] FAIL rnd_adr@%0d: got %h expected %h", n, bus.Adr_o, e_adr); end
            checks++; if (bus.WriteData_o !== e_wd) begin failures++; $display("[TB] FAIL rnd_wd@%0d: got %h expected %h", n, bus.WriteData_o, e_wd); end
            checks++; if ({bus.op_o, bus.funct3_o, bus.funct7_o} !== {e_op, e_f3, e_f7}) begin failures++; $display("[TB] FAIL rnd_decode@%0d: got %h/%h/%b expected %h/%h/%b", n, bus.op_o, bus.funct3_o, bus.funct7_o, e_op, e_f3, e_f7); end
            checks++; if (bus.zero_o !== e_zero) begin failures++; $display("[TB] FAIL rnd_zero@%0d: got %b expected %b", n, bus.zero_o, e_zero); end
            checks++; if (bus.misalign_o !== e_mis) begin failures++; $display("[TB] FAIL rnd_misalign@%0d: got %b expected %b", n, bus.misalign_o, e_mis); end
            clockEdge();
        end
    endtask

    initial begin
        $display("[TB] starting ucsbece154a_datapath bench");
        test_reset();
        test_fetch();
        test_addi();
        test_alu();
        test_lui();
        test_load_store();
        test_reset_midinstr();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
